encrypt_arbiter: RTL and testbench
==================================

Name: encrypt_arbiter

Overview:
Shares one 8-bit ENCRYPT engine between two requesters. Each requester presents a number and a key over a valid/ready handshake. The arbiter grants one request at a time with round-robin priority and holds the engine operands stable for the engine's latency. It then returns the result with a requester ID over a valid/ready response channel that honours backpressure. It sits between the requester logic and the ENCRYPT instance, and drives that instance's number/key inputs.

Parameters:
W, 8, datapath width of number, key and result
ENG_LATENCY, 1, clock edges from stable engine inputs to valid engine output; legal range 1..15
CNT_W, 16, width of the completed-operation counter

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
req_valid  input  2  request valid, one bit per requester (bit0 = requester 0)
req_ready  output  2  request accepted; at most one bit high
req_number0  input  W  requester 0 plaintext
req_key0  input  W  requester 0 key
req_number1  input  W  requester 1 plaintext
req_key1  input  W  requester 1 key
eng_number  output  W  operand to ENCRYPT number input
eng_key  output  W  operand to ENCRYPT key input
eng_result  input  W  ENCRYPT encrypted output
rsp_valid  output  1  response valid
rsp_ready  input  1  response consumer ready
rsp_id  output  1  requester that owns the response
rsp_data  output  W  encrypted result
busy  output  1  high in any state other than IDLE
op_count  output  CNT_W  completed responses, wraps modulo 2^CNT_W

Behaviour:
- Reset (reset = 0, asynchronous):
  - state = IDLE; rr_ptr = 0 (requester 0 has priority).
  - All outputs 0: req_ready, eng_number, eng_key, rsp_valid, rsp_id, rsp_data, busy, op_count. Internal latency counter = 0.
  - Reset mid-operation discards the in-flight request silently. No response is produced for it.
- State machine: IDLE -> BUSY -> RESP -> IDLE.
- IDLE:
  - req_ready is combinational. grant = rr_ptr if req_valid[rr_ptr], else the other requester if it is valid.
  - req_ready[grant] = 1; the other bit is 0.
  - If no request is valid, req_ready = 00 and the state holds.
  - On the handshake edge: eng_number, eng_key and id are registered from the granted requester; cnt = ENG_LATENCY; rr_ptr = ~grant; go to BUSY.
- BUSY:
  - req_ready = 00. eng_number/eng_key are held constant.
  - cnt decrements every cycle. On the edge where cnt == 1: rsp_data = eng_result, rsp_id = id, rsp_valid = 1; go to RESP.
  - BUSY therefore lasts exactly ENG_LATENCY cycles.
- RESP:
  - rsp_valid = 1; rsp_data and rsp_id are stable until accepted.
  - On an edge with rsp_ready = 1: rsp_valid = 0, op_count += 1 (wraps), go to IDLE.
  - No new grant occurs in the same cycle as the response handshake.
- Latency and throughput:
  - Request handshake to rsp_valid = ENG_LATENCY + 1 edges.
  - Minimum issue interval = ENG_LATENCY + 2 cycles, with rsp_ready tied high.
- eng_number/eng_key keep their last values after completion. They change only on a new grant.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1... The winner of each grant loses priority to the other requester next time.
- Requester operands need only be stable in the handshake cycle.
- A requester dropping req_valid while not granted is legal and has no effect.
- rsp_ready held low keeps the state in RESP indefinitely. No requests are accepted during that time.

Decomposition:
- Shared package: state encoding (IDLE=2'd0, BUSY=2'd1, RESP=2'd2) and width constant W = 8.
- One natural sub-module, rr_arbiter2: a 2-way round-robin grant from req_valid and rr_ptr.
- The ENCRYPT instance stays outside this block; a top-level wrapper connects the two.

Test Plan:
- The bench drives eng_result from a stub engine: result = registered (eng_number ^ eng_key), with ENG_LATENCY = 1.
- Single request: requester 0 sends 0x46/0x93 with rsp_ready = 1 -> rsp_valid 2 edges after the handshake, rsp_id = 0, rsp_data = 0xD5, op_count = 1.
- Simultaneous requests: requester 0 sends 0xC9/0xAC and requester 1 sends 0xA5/0x5A, both valid -> responses in order (id 0, 0x65) then (id 1, 0xFF). The second grant occurs 3 cycles after the first.
- Fairness: both requesters valid for 6 grants -> grant sequence 0,1,0,1,0,1; op_count = 6.
- Backpressure: requester 1 sends 0xF0/0xB1 with rsp_ready = 0 for 5 cycles -> rsp_valid held, rsp_data = 0x41 stable, req_ready = 00 and busy = 1 throughout. Raising rsp_ready completes the transfer in one edge.
- Reset mid-BUSY: assert reset asynchronously between clock edges -> all outputs 0 immediately and no response appears. After release, requester 1 alone is valid and is granted while rr_ptr = 0.
- Counter wrap: with CNT_W = 4, run 17 responses -> op_count = 1.

Source files
------------

// File: rtl/encrypt_arbiter_pkg.sv
`default_nettype none
//============================================================================
// Module  : encrypt_arbiter_pkg
// Desc    : Shared types and constants for the ENCRYPT engine arbiter.
// Rev     : 1.0  initial release
//============================================================================
package encrypt_arbiter_pkg;

    // Default datapath width of number, key and result.
    localparam int C_W     = 8;

    // Width of the engine latency counter; covers ENG_LATENCY up to 15.
    localparam int C_LAT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/encrypt_arbiter_if.sv
`default_nettype none
//============================================================================
// Module  : encrypt_arbiter_if
// Desc    : Request, engine and response signals of the ENCRYPT arbiter.
//           'slave' is the arbiter side, 'master' the surrounding logic.
// Rev     : 1.0  initial release
//============================================================================
interface encrypt_arbiter_if #(
    parameter int W     = encrypt_arbiter_pkg::C_W,
    parameter int CNT_W = 16
);
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [W-1:0]     req_number0;
    logic [W-1:0]     req_key0;
    logic [W-1:0]     req_number1;
    logic [W-1:0]     req_key1;
    logic [W-1:0]     eng_number;
    logic [W-1:0]     eng_key;
    logic [W-1:0]     eng_result;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [W-1:0]     rsp_data;
    logic             busy;
    logic [CNT_W-1:0] op_count;

    modport slave (
        input  req_valid, req_number0, req_key0, req_number1, req_key1,
        input  eng_result, rsp_ready,
        output req_ready, eng_number, eng_key,
        output rsp_valid, rsp_id, rsp_data, busy, op_count
    );

    modport master (
        output req_valid, req_number0, req_key0, req_number1, req_key1,
        output eng_result, rsp_ready,
        input  req_ready, eng_number, eng_key,
        input  rsp_valid, rsp_id, rsp_data, busy, op_count
    );
endinterface
`default_nettype wire

// File: rtl/encrypt_arbiter_rr_arbiter2.sv
`default_nettype none
//============================================================================
// Module  : encrypt_arbiter_rr_arbiter2
// Desc    : Two-way round-robin grant. The requester named by i_ptr wins
//           when it asks; otherwise the other requester wins if it asks.
// Rev     : 1.0  initial release
//============================================================================
module encrypt_arbiter_rr_arbiter2 (
    input  logic [1:0] i_req,
    input  logic       i_ptr,
    output logic [1:0] o_grant_vec,
    output logic       o_grant_id
);

    // Priority holder first, then the other side; no grant when idle.
    always_comb begin
        o_grant_vec = 2'b00;
        o_grant_id  = i_ptr;
        if (i_req[i_ptr]) begin
            o_grant_vec[i_ptr] = 1'b1;
            o_grant_id         = i_ptr;
        end else if (i_req[~i_ptr]) begin
            o_grant_vec[~i_ptr] = 1'b1;
            o_grant_id          = ~i_ptr;
        end
    end

endmodule
`default_nettype wire

// File: rtl/encrypt_arbiter.sv
`default_nettype none
//============================================================================
// Module  : encrypt_arbiter
// Desc    : Shares one ENCRYPT engine between two requesters. Grants one
//           request at a time (round robin), holds the engine operands for
//           ENG_LATENCY cycles, then offers the result with its requester
//           ID on a back-pressured response channel.
// Rev     : 1.0  initial release
//============================================================================
module encrypt_arbiter
    import encrypt_arbiter_pkg::*;
#(
    parameter int W           = C_W,
    parameter int ENG_LATENCY = 1,
    parameter int CNT_W       = 16
) (
    input  logic             clock,
    input  logic             reset,
    encrypt_arbiter_if.slave bus
);

    localparam logic [C_LAT_W-1:0] C_LAT = C_LAT_W'(ENG_LATENCY);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_rr_ptr;
    logic [C_LAT_W-1:0] r_cnt;
    logic               r_id;
    logic [W-1:0]       r_eng_number;
    logic [W-1:0]       r_eng_key;
    logic [W-1:0]       r_rsp_data;
    logic               r_rsp_id;
    logic [CNT_W-1:0]   r_op_count;

    logic [1:0]         w_grant_vec;
    logic               w_grant_id;
    logic [1:0]         w_req_ready;
    logic               w_req_fire;
    logic               w_busy_done;
    logic               w_rsp_fire;

    encrypt_arbiter_rr_arbiter2 u_rr (
        .i_req       (bus.req_valid),
        .i_ptr       (r_rr_ptr),
        .o_grant_vec (w_grant_vec),
        .o_grant_id  (w_grant_id)
    );

    assign w_req_fire  = (r_state == IDLE) && (|bus.req_valid);
    assign w_busy_done = (r_state == BUSY) && (r_cnt == C_LAT_W'(1));
    assign w_rsp_fire  = (r_state == RESP) && bus.rsp_ready;

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and request-ready decode; ready is forced low while in reset.
    always_comb begin
        w_state_nxt = r_state;
        w_req_ready = 2'b00;
        case (r_state)
            IDLE: begin
                w_req_ready = reset ? w_grant_vec : 2'b00;
                if (|bus.req_valid) begin
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (r_cnt == C_LAT_W'(1)) begin
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Operand capture on grant, latency countdown, result capture, op counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rr_ptr     <= 1'b0;
            r_cnt        <= '0;
            r_id         <= 1'b0;
            r_eng_number <= '0;
            r_eng_key    <= '0;
            r_rsp_data   <= '0;
            r_rsp_id     <= 1'b0;
            r_op_count   <= '0;
        end else begin
            if (w_req_fire) begin
                r_eng_number <= w_grant_id ? bus.req_number1 : bus.req_number0;
                r_eng_key    <= w_grant_id ? bus.req_key1    : bus.req_key0;
                r_id         <= w_grant_id;
                r_cnt        <= C_LAT;
                r_rr_ptr     <= ~w_grant_id;
            end else if (r_state == BUSY) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_busy_done) begin
                r_rsp_data <= bus.eng_result;
                r_rsp_id   <= r_id;
            end
            if (w_rsp_fire) begin
                r_op_count <= r_op_count + 1'b1;
            end
        end
    end

    assign bus.req_ready  = w_req_ready;
    assign bus.eng_number = r_eng_number;
    assign bus.eng_key    = r_eng_key;
    assign bus.rsp_valid  = (r_state == RESP);
    assign bus.rsp_id     = r_rsp_id;
    assign bus.rsp_data   = r_rsp_data;
    assign bus.busy       = (r_state != IDLE);
    assign bus.op_count   = r_op_count;

endmodule
`default_nettype wire

// File: tb/tb_encrypt_arbiter.sv
`default_nettype none
//============================================================================
// Module  : tb_encrypt_arbiter
// Desc    : Self-checking bench for encrypt_arbiter with a stub XOR engine
//           and a transaction-level reference model.
// Rev     : 1.0  initial release
//============================================================================
module tb_encrypt_arbiter;

    localparam int W   = 8;
    localparam int LAT = 1;
    localparam int CW  = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;

    always #5 clock = ~clock;

    encrypt_arbiter_if #(.W(W), .CNT_W(CW)) bus ();

    encrypt_arbiter #(.W(W), .ENG_LATENCY(LAT), .CNT_W(CW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Stub engine: result registered on the falling edge, so it is valid one
    // rising edge after the operands settle.
    always @(negedge clock) bus.eng_result <= bus.eng_number ^ bus.eng_key;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Who wins given the valid bits and the current priority holder (-1: none).
    function automatic int pick(input logic [1:0] v, input bit p);
        if (v[p])  return int'(p);
        if (v[!p]) return int'(!p);
        return -1;
    endfunction

    // ---------------- reference model (transaction level) ----------------
    bit         m_init = 0;
    bit         m_inflight, m_pending, m_prio, m_id, m_rsp_id;
    int         m_left, m_count, m_g;
    logic [7:0] m_num, m_key, m_rsp_data;

    always @(posedge clock) begin
        if (!reset) begin
            m_init = 1; m_inflight = 0; m_pending = 0; m_prio = 0; m_id = 0;
            m_rsp_id = 0; m_left = 0; m_count = 0; m_num = 0; m_key = 0; m_rsp_data = 0;
        end else if (m_pending) begin
            if (bus.rsp_ready) begin
                m_pending = 0;
                m_count   = (m_count + 1) % (1 << CW);
            end
        end else if (m_inflight) begin
            m_left--;
            if (m_left == 0) begin
                m_inflight = 0;
                m_pending  = 1;
                m_rsp_id   = m_id;
                m_rsp_data = m_num ^ m_key;
            end
        end else begin
            m_g = pick(bus.req_valid, m_prio);
            if (m_g >= 0) begin
                m_id       = (m_g == 1);
                m_num      = m_id ? bus.req_number1 : bus.req_number0;
                m_key      = m_id ? bus.req_key1    : bus.req_key0;
                m_prio     = !m_id;
                m_left     = LAT;
                m_inflight = 1;
            end
        end
    end

    // ---------------- every-cycle compare ----------------
    logic [1:0] exp_ready;
    int         cg;

    always @(negedge clock) begin
        if (reset && m_init) begin
            exp_ready = 2'b00;
            if (!m_inflight && !m_pending) begin
                cg = pick(bus.req_valid, m_prio);
                if (cg >= 0) exp_ready[cg] = 1'b1;
            end
            check("req_ready",  bus.req_ready,  exp_ready);
            check("busy",       bus.busy,       m_inflight | m_pending);
            check("rsp_valid",  bus.rsp_valid,  m_pending);
            check("op_count",   bus.op_count,   m_count);
            check("eng_number", bus.eng_number, m_num);
            check("eng_key",    bus.eng_key,    m_key);
            if (m_pending) begin
                check("rsp_id",   bus.rsp_id,   m_rsp_id);
                check("rsp_data", bus.rsp_data, m_rsp_data);
            end
        end
    end

    // ---------------- handshake monitor ----------------
    int         cyc = 0;
    int         g_ids[$];
    int         g_cyc[$];
    logic [8:0] rsp_q[$];

    always @(posedge clock) begin
        cyc++;
        if (reset && ((bus.req_valid & bus.req_ready) != 2'b00)) begin
            g_ids.push_back(int'(bus.req_ready[1]));
            g_cyc.push_back(cyc);
        end
        if (reset && bus.rsp_valid && bus.rsp_ready) rsp_q.push_back({bus.rsp_id, bus.rsp_data});
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        g_ids.delete();
        g_cyc.delete();
        rsp_q.delete();
    endtask

    task automatic wait_grants(input int n);
        for (int i = 0; i < 300 && g_ids.size() < n; i++) tick();
        check("grant_count", g_ids.size(), n);
    endtask

    task automatic wait_rsps(input int n);
        for (int i = 0; i < 300 && rsp_q.size() < n; i++) tick();
        check("rsp_count", rsp_q.size(), n);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_ready"},  bus.req_ready,  0);
        check({tag, "_eng_number"}, bus.eng_number, 0);
        check({tag, "_eng_key"},    bus.eng_key,    0);
        check({tag, "_rsp_valid"},  bus.rsp_valid,  0);
        check({tag, "_rsp_id"},     bus.rsp_id,     0);
        check({tag, "_rsp_data"},   bus.rsp_data,   0);
        check({tag, "_busy"},       bus.busy,       0);
        check({tag, "_op_count"},   bus.op_count,   0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int n0;

    initial begin
        bus.req_valid   = 2'b00;
        bus.req_number0 = '0;
        bus.req_key0    = '0;
        bus.req_number1 = '0;
        bus.req_key1    = '0;
        bus.rsp_ready   = 1'b0;

        // Reset state.
        repeat (2) @(posedge clock);
        #1;
        check_all_zero("reset");
        reset = 1'b1;
        tick();

        // Single request: response visible on the second edge counting the
        // handshake edge; 0x46 ^ 0x93 = 0xD5.
        bus.req_valid   = 2'b01;
        bus.req_number0 = 8'h46;
        bus.req_key0    = 8'h93;
        bus.rsp_ready   = 1'b1;
        @(negedge clock);
        check("single_ready", bus.req_ready, 2'b01);
        tick();
        bus.req_valid = 2'b00;
        check("single_busy", bus.busy, 1);
        check("single_rsp_early", bus.rsp_valid, 0);
        tick();
        check("single_rsp_valid", bus.rsp_valid, 1);
        check("single_rsp_id", bus.rsp_id, 0);
        check("single_rsp_data", bus.rsp_data, 8'hD5);
        tick();
        check("single_rsp_done", bus.rsp_valid, 0);
        check("single_op_count", bus.op_count, 1);

        // Simultaneous requests, then continued contention for fairness.
        do_reset();
        bus.req_number0 = 8'hC9;
        bus.req_key0    = 8'hAC;
        bus.req_number1 = 8'hA5;
        bus.req_key1    = 8'h5A;
        bus.rsp_ready   = 1'b1;
        bus.req_valid   = 2'b11;
        wait_grants(6);
        bus.req_valid = 2'b00;
        wait_rsps(6);
        for (int i = 0; i < 6; i++)
            check($sformatf("fair_grant%0d", i), (i < g_ids.size()) ? g_ids[i] : -1, i % 2);
        check("simul_interval", (g_cyc.size() > 1) ? g_cyc[1] - g_cyc[0] : -1, 3);
        check("simul_rsp0", (rsp_q.size() > 0) ? rsp_q[0] : 9'h000, 9'h065);
        check("simul_rsp1", (rsp_q.size() > 1) ? rsp_q[1] : 9'h000, 9'h1FF);
        check("fair_op_count", bus.op_count, 6);

        // Backpressure: response held while rsp_ready is low; 0xF0 ^ 0xB1 = 0x41.
        do_reset();
        bus.rsp_ready   = 1'b0;
        bus.req_number1 = 8'hF0;
        bus.req_key1    = 8'hB1;
        bus.req_valid   = 2'b10;
        wait_grants(1);
        bus.req_valid = 2'b11;
        for (int i = 0; i < 20 && !bus.rsp_valid; i++) tick();
        check("bp_rsp_seen", bus.rsp_valid, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("bp_rsp_valid", bus.rsp_valid, 1);
            check("bp_rsp_data",  bus.rsp_data,  8'h41);
            check("bp_rsp_id",    bus.rsp_id,    1);
            check("bp_req_ready", bus.req_ready, 2'b00);
            check("bp_busy",      bus.busy,      1);
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.req_valid = 2'b00;
        check("bp_rsp_done", bus.rsp_valid, 0);
        check("bp_op_count", bus.op_count, 1);
        check("bp_grants", g_ids.size(), 1);

        // Reset asserted between edges while BUSY.
        bus.req_number0 = 8'h3C;
        bus.req_key0    = 8'h7E;
        bus.req_valid   = 2'b01;
        wait_grants(2);
        bus.req_valid = 2'b00;
        n0 = rsp_q.size();
        #2;
        check("rst_pre_busy", bus.busy, 1);
        reset = 1'b0;
        #1;
        check_all_zero("rst_mid");
        tick();
        tick();
        reset = 1'b1;
        repeat (4) tick();
        check("rst_no_rsp", rsp_q.size(), n0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        bus.req_valid = 2'b10;
        @(negedge clock);
        check("rst_req1_ready", bus.req_ready, 2'b10);
        tick();
        bus.req_valid = 2'b00;
        wait_rsps(n0 + 1);
        check("rst_rsp_id", (rsp_q.size() > n0) ? rsp_q[n0][8] : 1'b0, 1);

        // Counter wrap with a 4-bit counter: 17 responses leave 1.
        do_reset();
        bus.rsp_ready = 1'b1;
        bus.req_valid = 2'b11;
        wait_grants(17);
        bus.req_valid = 2'b00;
        wait_rsps(17);
        check("wrap_op_count", bus.op_count, 1);

        // Randomized traffic checked against the model every cycle.
        do_reset();
        for (int i = 0; i < 800; i++) begin
            bus.req_valid   = 2'($urandom);
            bus.req_number0 = 8'($urandom);
            bus.req_key0    = 8'($urandom);
            bus.req_number1 = 8'($urandom);
            bus.req_key1    = 8'($urandom);
            bus.rsp_ready   = ($urandom_range(0, 3) != 0);
            tick();
        end
        bus.req_valid = 2'b00;
        bus.rsp_ready = 1'b1;
        repeat (5) tick();
        check("rand_idle", bus.busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
